relu_bound_vec: RTL and testbench

RELU_BOUND_VEC -- requirements
Module: relu_bound_vec

---
 rtl/relu_bound_vec.sv | 139 +++++++++++++
 tb/tb_relu_bound_vec.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/relu_bound_vec.sv
// Vector ReLU / bounded-ReLU with a two-stage valid/ready pipeline.
// S1 captures a beat with its mode and bound, and S2 holds the clamped result.
module relu_bound_vec #(
    parameter int W     = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_data,
    input  logic [1:0]           mode,
    input  logic [W-2:0]         bound,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_data,
    output logic [CNT_W-1:0]     clamp_cnt,
    input  logic                 cnt_clr
);

    localparam int NCL_W = $clog2(LANES + 1);
    localparam int SUM_W = CNT_W + NCL_W;
    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_BND  = 2'b10;

    // Mode 11 falls through to the plain ReLU path.
    function automatic logic signed [W-1:0] relu_lane(
        input logic signed [W-1:0] x,
        input logic [1:0]          m,
        input logic [W-2:0]        b
    );
        if (m == MODE_PASS)
            relu_lane = x;
        else if (x[W-1])
            relu_lane = '0;
        else if ((m == MODE_BND) && (x[W-2:0] > b))
            relu_lane = {1'b0, b};
        else
            relu_lane = x;
    endfunction

    function automatic logic clamp_hit(
        input logic signed [W-1:0] x,
        input logic [1:0]          m,
        input logic [W-2:0]        b
    );
        clamp_hit = (m == MODE_BND) && !x[W-1] && (x[W-2:0] > b);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] c,
        input logic [NCL_W-1:0] n
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(c) + SUM_W'(n);
        if (s[SUM_W-1:CNT_W] != '0)
            sat_add = '1;
        else
            sat_add = s[CNT_W-1:0];
    endfunction

    logic                 vld_p1;
    logic [LANES*W-1:0]   data_p1;
    logic [1:0]           mode_p1;
    logic [W-2:0]         bound_p1;

    logic                 vld_p2;
    logic [LANES*W-1:0]   data_p2;
    logic [NCL_W-1:0]     ncl_p2;

    logic [LANES*W-1:0]   res_p1;
    logic [NCL_W-1:0]     ncl_p1;
    logic                 adv_p2;
    logic                 ld_p1;
    logic                 xfer_out;

    // A stage loads when empty or when its contents move on this cycle.
    assign adv_p2   = !vld_p2 || out_ready;
    assign ld_p1    = !vld_p1 || adv_p2;
    assign in_ready = ld_p1;
    assign xfer_out = vld_p2 && out_ready;

    assign out_valid = vld_p2;
    assign out_data  = data_p2;

    // ---- S0 -> S1: capture beat with its mode and bound ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (ld_p1)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (ld_p1 && in_valid) begin
            data_p1  <= in_data;
            mode_p1  <= mode;
            bound_p1 <= bound;
        end
    end

    always_comb begin
        res_p1 = '0;
        ncl_p1 = '0;
        for (int i = 0; i < LANES; i++) begin
            res_p1[i*W +: W] = relu_lane(data_p1[i*W +: W], mode_p1, bound_p1);
            ncl_p1           = ncl_p1 + NCL_W'(clamp_hit(data_p1[i*W +: W], mode_p1, bound_p1));
        end
    end

    // ---- S1 -> S2: register clamped result and its clamp tally ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                data_p2 <= res_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p2 && vld_p1)
            ncl_p2 <= ncl_p1;
    end

    // Clamp events are credited when the beat leaves; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            clamp_cnt <= '0;
        else if (cnt_clr)
            clamp_cnt <= '0;
        else if (xfer_out)
            clamp_cnt <= sat_add(clamp_cnt, ncl_p2);
    end

endmodule

// File: tb/tb_relu_bound_vec.sv
// Directed bench for relu_bound_vec with W=8, LANES=4, CNT_W=4.
module tb_relu_bound_vec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  mode;
    logic [6:0]  bound;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  clamp_cnt;
    logic        cnt_clr;

    int n_assert = 0;
    int n_fail   = 0;

    relu_bound_vec #(.W(8), .LANES(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mode(mode), .bound(bound),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .clamp_cnt(clamp_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [6:0] b, input logic [31:0] d);
        in_valid = v;
        mode     = m;
        bound    = b;
        in_data  = d;
    endtask

    function automatic logic [31:0] pack(input int l0, input int l1, input int l2, input int l3);
        pack = {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    // Reference lane behaviour in plain integer arithmetic.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] m, input int b);
        logic [31:0] r;
        logic [7:0]  lane;
        int          v;
        int          o;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            lane = d[i*8 +: 8];
            v    = int'($signed(lane));
            if (m == 2'b00)                o = v;
            else if (v < 0)                o = 0;
            else if (m == 2'b10 && v > b)  o = b;
            else                           o = v;
            r[i*8 +: 8] = o[7:0];
        end
        model = r;
    endfunction

    initial begin
        logic [31:0] d;
        logic [1:0]  m;

        rst = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
        drive(1'b0, 2'b00, 7'd0, 32'h0);
        #3;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data, 32'h0);
        chk("rst_clamp_cnt", {28'b0, clamp_cnt}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        step(); step();
        rst = 1'b0;

        // ReLU on extreme lanes, two-cycle latency
        drive(1'b1, 2'b01, 7'd0, 32'h7f00ff80);
        step();
        drive(1'b0, 2'b00, 7'd0, 32'h0);
        chk("relu_lat1_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("relu_valid", {31'b0, out_valid}, 32'd1);
        chk("relu_data",  out_data, 32'h7f000000);
        step();
        chk("relu_drained", {31'b0, out_valid}, 32'd0);
        chk("relu_cnt",     {28'b0, clamp_cnt}, 32'd0);

        // Bounded ReLU, bound 6
        drive(1'b1, 2'b10, 7'd6, 32'h640603fb);
        step();
        drive(1'b0, 2'b00, 7'd0, 32'h0);
        step();
        chk("bnd_data",       out_data, 32'h06060300);
        chk("bnd_cnt_before", {28'b0, clamp_cnt}, 32'd0);
        step();
        chk("bnd_cnt_after",  {28'b0, clamp_cnt}, 32'd1);

        // Eight back-to-back beats alternating pass / bounded
        for (int k = 0; k < 10; k++) begin
            if (k < 8)
                drive(1'b1, (k % 2 == 1) ? 2'b10 : 2'b00, 7'd6, pack(-k, k, 8 + k, 100 - k));
            else
                drive(1'b0, 2'b00, 7'd0, 32'h0);
            step();
            if (k >= 1 && k <= 8) begin
                d = pack(-(k - 1), k - 1, 8 + k - 1, 100 - (k - 1));
                m = ((k - 1) % 2 == 1) ? 2'b10 : 2'b00;
                chk($sformatf("stream_valid_%0d", k - 1), {31'b0, out_valid}, 32'd1);
                chk($sformatf("stream_data_%0d", k - 1), out_data, model(d, m, 6));
            end
        end
        chk("stream_idle", {31'b0, out_valid}, 32'd0);
        chk("stream_cnt",  {28'b0, clamp_cnt}, 32'd10);

        // Backpressure: fill both stages, then drain
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 7'd0, pack(1, 2, 3, -4));
        #1 chk("bp_ready_a", {31'b0, in_ready}, 32'd1);
        step();
        drive(1'b1, 2'b10, 7'd2, pack(5, 1, -1, 2));
        chk("bp_ready_b", {31'b0, in_ready}, 32'd1);
        step();
        drive(1'b1, 2'b00, 7'd0, 32'h09090909);
        chk("bp_ready_full", {31'b0, in_ready}, 32'd0);
        chk("bp_valid",      {31'b0, out_valid}, 32'd1);
        chk("bp_data_a",     out_data, 32'h00030201);
        step(); step();
        chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_hold_data",  out_data, 32'h00030201);
        out_ready = 1'b1;
        #1 chk("bp_ready_release", {31'b0, in_ready}, 32'd1);
        step();
        drive(1'b0, 2'b00, 7'd0, 32'h0);
        chk("bp_data_b", out_data, 32'h02000102);
        step();
        chk("bp_data_c", out_data, 32'h09090909);
        step();
        chk("bp_empty",  {31'b0, out_valid}, 32'd0);
        chk("bp_cnt",    {28'b0, clamp_cnt}, 32'd11);

        // Counter clear and saturation
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_cnt", {28'b0, clamp_cnt}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'b10, 7'd0, 32'h01010101);
            step();
        end
        drive(1'b0, 2'b00, 7'd0, 32'h0);
        chk("sat_mid_cnt",  {28'b0, clamp_cnt}, 32'd12);
        chk("sat_mid_data", out_data, 32'h0);
        step();
        chk("sat_cnt_16",   {28'b0, clamp_cnt}, 32'd15);
        step();
        chk("sat_cnt_final", {28'b0, clamp_cnt}, 32'd15);
        drive(1'b1, 2'b10, 7'd0, 32'h01010101);
        step();
        drive(1'b0, 2'b00, 7'd0, 32'h0);
        step();
        chk("clr_xfer_valid", {31'b0, out_valid}, 32'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_xfer_cnt", {28'b0, clamp_cnt}, 32'd0);

        // Reset with two beats in flight
        drive(1'b1, 2'b10, 7'd0, 32'h01010101);
        step();
        drive(1'b0, 2'b00, 7'd0, 32'h0);
        step(); step();
        chk("pre_rst_cnt", {28'b0, clamp_cnt}, 32'd4);
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 7'd0, 32'h01010101);
        step();
        drive(1'b1, 2'b00, 7'd0, 32'h05050505);
        step();
        drive(1'b0, 2'b00, 7'd0, 32'h0);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("pre_rst_ready", {31'b0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_cnt",   {28'b0, clamp_cnt}, 32'd0);
        chk("async_rst_data",  out_data, 32'h0);
        chk("async_rst_ready", {31'b0, in_ready}, 32'd1);
        step(); step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 7'd0, pack(-3, 7, 0, 20));
        step();
        drive(1'b0, 2'b00, 7'd0, 32'h0);
        chk("post_rst_no_stale", {31'b0, out_valid}, 32'd0);
        step();
        chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_data",  out_data, pack(0, 7, 0, 20));
        step();
        chk("post_rst_empty", {31'b0, out_valid}, 32'd0);
        chk("post_rst_cnt",   {28'b0, clamp_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
